// File: rtl/valrdy_pkg.sv
// Shared types for the val/rdy queue library front ends.
package valrdy_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deserializer_valrdy_bit_counter.sv
// Bit-position counter 0..MAX; wraps to 0 on an increment at MAX, load sets it to 1.
module bit_counter #(
  parameter int CNT_W = 5,
  parameter int MAX   = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == CNT_W'(MAX));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      count <= at_max ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer_valrdy.sv
// Serial-to-parallel front end: frames BITWIDTH bits MSB first into a word and
// presents it on a val/rdy port through a single output register.
module deserializer_valrdy
  import valrdy_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                SER_VAL,
  output logic                SER_RDY,
  input  logic                SER_BIT,
  input  logic                FRAME_START,
  output logic                OUT_VAL,
  input  logic                OUT_RDY,
  output logic [BITWIDTH-1:0] OUT_DATA,
  output logic                SYNC_ERR
);

  localparam int CNT_W = $clog2(BITWIDTH);

  deser_state_t          state, state_next;
  logic [BITWIDTH-1:0]   sreg;
  logic [CNT_W-1:0]      count;
  logic                  at_last;
  logic                  accept;
  logic                  consume;
  logic                  complete;

  // Handshakes: a bit moves when SER_VAL & SER_RDY, a word moves when
  // OUT_VAL & OUT_RDY. SER_RDY only drops when the last bit of a word would
  // land on a full, stalled output register.
  assign SER_RDY  = ~(at_last & OUT_VAL & ~OUT_RDY);
  assign accept   = SER_VAL & SER_RDY;
  assign consume  = OUT_VAL & OUT_RDY;
  assign complete = accept & ~FRAME_START & at_last;

  bit_counter #(
    .CNT_W (CNT_W),
    .MAX   (BITWIDTH - 1)
  ) u_bit_counter (
    .clk   (CLK),
    .rst_n (RESET_N),
    .inc   (accept & ~FRAME_START),
    .load1 (accept & FRAME_START),
    .clr   (1'b0),
    .count (count),
    .at_max(at_last)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= {sreg[BITWIDTH-2:0], SER_BIT};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      OUT_DATA <= '0;
    end else if (complete) begin
      OUT_DATA <= {sreg[BITWIDTH-2:0], SER_BIT};
    end
  end

  // A resync lands mid-word whenever the counter has already moved off zero.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      SYNC_ERR <= 1'b0;
    end else if (accept && FRAME_START && (count != '0)) begin
      SYNC_ERR <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (complete)              state_next = S_FULL;
      S_FULL:  if (consume && !complete)  state_next = S_EMPTY;
      default:                            state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    OUT_VAL = (state == S_FULL);
  end

endmodule
